// File: rtl/result_string_ctrl.sv
// Binary result -> 4-char ASCII field via repeated subtraction, committed only in vblank.
// The string output is named str because "string" is a reserved SystemVerilog keyword.
module result_string_ctrl #(
    parameter int VAL_W    = 14,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] value,
    input  logic             vblnk,
    output logic [31:0]      str,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, CONV, WAIT_VBLNK} state_t;

    localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(9999);

    state_t           state, state_nxt;
    logic [VAL_W-1:0] rem;
    logic [3:0]       digit;
    logic [1:0]       idx;
    logic [31:0]      staged;
    logic             ovf_stage;
    logic [VAL_W-1:0] w;
    logic             take;
    logic [31:0]      staged_ins, staged_fin;

    function automatic logic [VAL_W-1:0] weight(input logic [1:0] i);
        case (i)
            2'd3:    return VAL_W'(1000);
            2'd2:    return VAL_W'(100);
            2'd1:    return VAL_W'(10);
            default: return VAL_W'(1);
        endcase
    endfunction

    // Zeros above the first nonzero digit become spaces; units byte always kept.
    function automatic logic [31:0] blank_lz(input logic [31:0] s);
        logic [31:0] b;
        b = s;
        if (b[31:24] == 8'h30) begin
            b[31:24] = 8'h20;
            if (b[23:16] == 8'h30) begin
                b[23:16] = 8'h20;
                if (b[15:8] == 8'h30) b[15:8] = 8'h20;
            end
        end
        return b;
    endfunction

    always_comb begin
        w          = weight(idx);
        take       = (rem >= w);
        staged_ins = staged;
        staged_ins[{idx, 3'b000} +: 8] = {4'h3, digit};
        staged_fin = LZ_BLANK ? blank_lz(staged_ins) : staged_ins;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = (value > MAX_VAL) ? WAIT_VBLNK : CONV;
            CONV:       if (!take && idx == 2'd0) state_nxt = WAIT_VBLNK;
            WAIT_VBLNK: if (vblnk) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            str       <= 32'h20202020;
            done      <= 1'b0;
            overflow  <= 1'b0;
            rem       <= '0;
            digit     <= '0;
            idx       <= '0;
            staged    <= '0;
            ovf_stage <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rem <= value;
                    if (value > MAX_VAL) begin
                        staged    <= 32'h2D2D2D2D;
                        ovf_stage <= 1'b1;
                    end else begin
                        idx       <= 2'd3;
                        digit     <= 4'd0;
                        ovf_stage <= 1'b0;
                    end
                end
                CONV: begin
                    if (take) begin
                        rem   <= rem - w;
                        digit <= digit + 4'd1;
                    end else begin
                        staged <= (idx == 2'd0) ? staged_fin : staged_ins;
                        digit  <= 4'd0;
                        if (idx != 2'd0) idx <= idx - 2'd1;
                    end
                end
                WAIT_VBLNK: if (vblnk) begin
                    str      <= staged;
                    overflow <= ovf_stage;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_result_string_ctrl.sv
// Bench for result_string_ctrl: decimal-arithmetic model checked every cycle plus directed literals.
module tb_result_string_ctrl;
    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] value = '0;
    logic        vblnk = 1'b1;
    logic [31:0] str1, str0;
    logic        busy1, busy0, done1, done0, ovf1, ovf0;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    result_string_ctrl #(.VAL_W(14), .LZ_BLANK(1'b1)) dut (
        .pclk(pclk), .rst_n(rst_n), .start(start), .value(value), .vblnk(vblnk),
        .str(str1), .busy(busy1), .done(done1), .overflow(ovf1));
    result_string_ctrl #(.VAL_W(14), .LZ_BLANK(1'b0)) dut0 (
        .pclk(pclk), .rst_n(rst_n), .start(start), .value(value), .vblnk(vblnk),
        .str(str0), .busy(busy0), .done(done0), .overflow(ovf0));

    always #5 pclk = ~pclk;

    function automatic logic [31:0] fmt(input int v, input bit lz);
        logic [31:0] s;
        int d[4];
        bit lead;
        if (v > 9999) return 32'h2D2D2D2D;
        d[3] = v / 1000; d[2] = (v / 100) % 10; d[1] = (v / 10) % 10; d[0] = v % 10;
        lead = 1;
        for (int i = 3; i >= 0; i--) begin
            if (lz && lead && d[i] == 0 && i != 0) s[i*8 +: 8] = 8'h20;
            else begin
                lead = 0;
                s[i*8 +: 8] = 8'h30 + 8'(d[i]);
            end
        end
        return s;
    endfunction

    // Model: a job needs digitsum+4 conversion cycles (none on overflow), then waits for vblank.
    bit          m_busy, m_done, m_ovf, m_ovf_st;
    int          m_cnt;
    logic [31:0] m_str1, m_str0, m_st1, m_st0;

    always @(posedge pclk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_ovf = 0; m_cnt = 0;
            m_str1 = 32'h20202020; m_str0 = 32'h20202020;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    int v;
                    v = int'(value);
                    m_busy = 1;
                    m_st1 = fmt(v, 1); m_st0 = fmt(v, 0);
                    m_ovf_st = (v > 9999);
                    m_cnt = m_ovf_st ? 0 :
                        (v / 1000) + (v / 100) % 10 + (v / 10) % 10 + v % 10 + 4;
                end
            end else if (m_cnt > 0) m_cnt--;
            else if (vblnk) begin
                m_str1 = m_st1; m_str0 = m_st0; m_ovf = m_ovf_st;
                m_busy = 0; m_done = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
        if (chk_en) begin
            chk("model str lz1", str1, m_str1);
            chk("model str lz0", str0, m_str0);
            chk("model busy", {30'd0, busy1, busy0}, {30'd0, m_busy, m_busy});
            chk("model done", {30'd0, done1, done0}, {30'd0, m_done, m_done});
            chk("model ovf", {30'd0, ovf1, ovf0}, {30'd0, m_ovf, m_ovf});
        end
    endtask

    task automatic pulse_start(input int v);
        start = 1; value = 14'(v);
        tick();
        start = 0;
    endtask

    // Cycles from the accepting edge until done is seen; 0 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (done1) begin cyc = i; break; end
        end
        if (cyc == 0) chk("done timeout", 32'd0, 32'd1);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done1 || done0) cnt++;
        end
    endtask

    task automatic run(input int v, input logic [31:0] exp1, input logic [31:0] exp0);
        int c;
        pulse_start(v);
        wait_done(c);
        chk("lit str lz1", str1, exp1);
        chk("lit str lz0", str0, exp0);
        tick();
    endtask

    initial begin
        int c;
        tick(); tick();
        rst_n = 1;
        chk_en = 1;
        chk("reset str", str1, 32'h20202020);
        chk("reset busy/done/ovf", {29'd0, busy1, done1, ovf1}, 32'd0);

        pulse_start(1234);
        wait_done(c);
        chk("1234 latency", 32'(c), 32'd15);
        chk("1234 str", str1, 32'h31323334);
        chk("1234 busy falls with done", {31'd0, busy1}, 32'd0);
        chk("1234 ovf", {31'd0, ovf1}, 32'd0);
        tick();

        run(7,    32'h20202037, 32'h30303037);
        run(0,    32'h20202030, 32'h30303030);
        run(1005, 32'h31303035, 32'h31303035);

        pulse_start(10000);
        wait_done(c);
        chk("ovf latency", 32'(c), 32'd1);
        chk("ovf str", str1, 32'h2D2D2D2D);
        chk("ovf flag", {31'd0, ovf1}, 32'd1);
        tick();
        run(42, 32'h20203432, 32'h30303432);
        chk("42 clears ovf", {31'd0, ovf1}, 32'd0);

        vblnk = 0;
        pulse_start(9999);
        for (int i = 0; i < 99; i++) tick();
        chk("9999 held busy", {31'd0, busy1}, 32'd1);
        chk("9999 str unchanged", str1, 32'h20203432);
        vblnk = 1;
        tick();
        chk("9999 done on vblnk", {31'd0, done1}, 32'd1);
        chk("9999 str", str1, 32'h39393939);
        tick();

        pulse_start(1234);
        tick();
        pulse_start(55);
        count_dones(40, c);
        chk("ignored start done count", 32'(c), 32'd1);
        chk("ignored start str", str1, 32'h31323334);

        pulse_start(9999);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("midreset str", str1, 32'h20202020);
        chk("midreset busy/done", {30'd0, busy1, done1}, 32'd0);
        count_dones(60, c);
        chk("midreset no done", 32'(c), 32'd0);
        run(8, 32'h20202038, 32'h30303038);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/result_string_ctrl.md
Name: result_string_ctrl

Overview:
- Converts a binary result value into the 4-character ASCII field consumed by the on-screen text page lookup (char positions 0x08..0x0B of the "Result:" page).
- Uses a start/busy/done handshake and a multi-cycle repeated-subtraction decimal converter.
- Commits the new string only while the display is in vertical blanking, so a frame never shows a half-updated result.
- Sits between the game/compute logic and the char_16x16 text page, in the pclk domain.

Parameters:
- VAL_W, 14, width of the binary input value (covers 0..9999 plus overflow detection).
- LZ_BLANK, 1, 1 = leading zeros shown as space 0x20; 0 = leading zeros shown as '0' 0x30.

Ports:
- pclk  input  1  pixel clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a conversion; sampled only in IDLE.
- value  input  VAL_W  binary result; captured on the accepted start edge.
- vblnk  input  1  vertical blanking flag from the timing generator; commit window.
- string  output  32  four ASCII chars, [31:24] thousands … [7:0] units; bit 7 of each byte always 0.
- busy  output  1  high from the accepted start until the commit edge.
- done  output  1  one-cycle pulse on the cycle string takes its new value.
- overflow  output  1  set if the last committed value exceeded 9999.

Behaviour:
- Reset, synchronous, rst_n=0 at an edge:
  - string=32'h20202020, busy=0, done=0, overflow=0, state=IDLE, internal digits, remainder and index cleared.
  - Reset mid-conversion or mid-wait abandons the job; no done pulse is generated.
- States: IDLE, CONV, WAIT_VBLNK.
- IDLE:
  - On an edge with start=1: capture value into rem.
  - If value>9999: stage "----" (8'h2D each) with ovf_stage=1 and go to WAIT_VBLNK.
  - Otherwise: idx=3, digit=0, ovf_stage=0, go to CONV.
  - busy=1 from this edge.
- CONV, one action per cycle. Weights are W[3..0]=1000,100,10,1.
  - If rem>=W[idx]: rem-=W[idx], digit++.
  - Else: stage digit into byte idx as 8'h30+digit, then digit=0.
    - If idx==0, go to WAIT_VBLNK; otherwise idx--.
  - Cycles spent in CONV = (sum of the decimal digits)+4.
- Leading-zero blanking, applied when leaving CONV:
  - If LZ_BLANK=1, each staged zero byte above the first nonzero digit becomes 8'h20.
  - The units byte is never blanked.
- WAIT_VBLNK:
  - On the first edge with vblnk=1: string<=staged, overflow<=ovf_stage, done=1 for that cycle, busy=0, go to IDLE.
  - If vblnk=1 on entry, the commit happens on the very next edge.
  - If vblnk=0, hold; string keeps its old value.
- Handshake:
  - start while busy=1 is ignored and not queued.
  - start may be asserted in the cycle done=1; it is accepted in IDLE on the following edge.
  - value only needs to be stable on the accepting edge.
- string changes only on commit edges or reset; it is stable otherwise.
- Total latency from the accepting edge to done (vblnk held high): 1 + (digitsum+4) edges, or 1 edge for overflow.

Test Plan:
- Reset, then value=1234, start one cycle, vblnk=1 constant:
  - done pulses exactly 15 cycles after the start edge.
  - string=32'h31323334, busy falls with done, overflow=0.
- LZ_BLANK=1:
  - value=7 -> string=32'h20202037.
  - value=0 -> 32'h20202030.
  - value=1005 -> 32'h31303035.
  - Repeat with LZ_BLANK=0: value=7 -> 32'h30303037.
- value=10000, vblnk=1:
  - done 1 cycle after the start edge.
  - string=32'h2D2D2D2D, overflow=1.
  - Next conversion of 42 clears overflow at its commit.
- value=9999 with vblnk=0:
  - busy stays 1 after CONV completes (40 cycles) and string is unchanged.
  - Raise vblnk at cycle 100 -> string=32'h39393939 with done on the next edge.
- Pulse start with value=55 while busy from a 1234 job -> only "1234" commits; a single done pulse.
- Assert rst_n=0 for one edge mid-CONV:
  - string=32'h20202020, busy=0, no done pulse.
  - A following start with value=8 yields 32'h20202038.
